// File: rtl/gray_count_monitor.sv
// Gray-count monitor: synchronises an asynchronous gray count, decodes it to binary
// and flags +1 / -1 / wrap steps plus a sticky multi-bit-change error.
module gray_count_monitor #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_gray,
    input  logic         i_clear_err,
    output logic [N-1:0] o_bin_count,
    output logic         o_valid,
    output logic         o_inc,
    output logic         o_dec,
    output logic         o_wrap,
    output logic         o_step_err
);

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int k = N - 2; k >= 0; k--) begin
            b[k] = g[k] ^ b[k+1];
        end
        return b;
    endfunction

    function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // More than one bit set iff clearing the lowest set bit leaves something.
    function automatic logic multi_bit(input logic [N-1:0] x);
        return (x & (x - N'(1))) != '0;
    endfunction

    logic [N-1:0] s1_q, s1_d;
    logic [N-1:0] s2_q, s2_d;
    logic [N-1:0] bin_q, bin_d;
    logic [1:0]   fill_q, fill_d;
    logic         valid_q, valid_d;
    logic         inc_q, inc_d;
    logic         dec_q, dec_d;
    logic         wrap_q, wrap_d;
    logic         err_q, err_d;
    logic         cmp;
    logic         step_bad;
    logic [N-1:0] diff;

    always_comb begin
        s1_d     = i_gray;
        s2_d     = s1_q;
        bin_d    = g2b(s2_q);
        fill_d   = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
        valid_d  = (fill_d == 2'd3);
        // Only compare once o_bin_count already holds a real decoded sample.
        cmp      = (fill_q == 2'd3);
        diff     = bin_d - bin_q;
        inc_d    = cmp && (diff == N'(1));
        dec_d    = cmp && (diff == {N{1'b1}});
        wrap_d   = cmp && (diff == N'(1)) && (bin_q == {N{1'b1}});
        step_bad = cmp && multi_bit(s2_q ^ b2g(bin_q));
        err_d    = step_bad | (err_q & ~i_clear_err);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            bin_q   <= '0;
            fill_q  <= 2'd0;
            valid_q <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            bin_q   <= bin_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign o_bin_count = bin_q;
    assign o_valid     = valid_q;
    assign o_inc       = inc_q;
    assign o_dec       = dec_q;
    assign o_wrap      = wrap_q;
    assign o_step_err  = err_q;

endmodule

// File: tb/tb_gray_count_monitor.sv
// Directed bench for gray_count_monitor: vector table for hold/decrement/error/clear
// behaviour, plus hand sequences for free-running count, wrap and mid-count reset.
module tb_gray_count_monitor;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [3:0] i_gray = 4'd0;
    logic       i_clear_err = 1'b0;
    logic [3:0] o_bin_count;
    logic       o_valid, o_inc, o_dec, o_wrap, o_step_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] gray;
        logic       clr;
        logic [3:0] bin;
        logic       v, inc, dec, wrap, err;
    } vec_t;

    vec_t tbl[26];

    gray_count_monitor #(.N(4)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_gray      (i_gray),
        .i_clear_err (i_clear_err),
        .o_bin_count (o_bin_count),
        .o_valid     (o_valid),
        .o_inc       (o_inc),
        .o_dec       (o_dec),
        .o_wrap      (o_wrap),
        .o_step_err  (o_step_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int idx, input logic [3:0] bin,
                            input logic v, input logic inc, input logic dec,
                            input logic wrap, input logic err);
        chk({tag, ".bin"},  idx, o_bin_count, bin);
        chk({tag, ".valid"}, idx, {3'b0, o_valid}, {3'b0, v});
        chk({tag, ".inc"},  idx, {3'b0, o_inc}, {3'b0, inc});
        chk({tag, ".dec"},  idx, {3'b0, o_dec}, {3'b0, dec});
        chk({tag, ".wrap"}, idx, {3'b0, o_wrap}, {3'b0, wrap});
        chk({tag, ".err"},  idx, {3'b0, o_step_err}, {3'b0, err});
    endtask

    task automatic set_v(input int i, input logic [3:0] g, input logic c, input logic [3:0] b,
                         input logic v, input logic inc, input logic dec,
                         input logic wrap, input logic err);
        tbl[i].gray = g; tbl[i].clr = c; tbl[i].bin = b;
        tbl[i].v = v; tbl[i].inc = inc; tbl[i].dec = dec; tbl[i].wrap = wrap; tbl[i].err = err;
    endtask

    // Leaves reset released one time unit after a rising edge.
    task automatic do_reset(input string tag);
        tick();
        i_reset = 1'b1;
        i_gray = 4'd0;
        i_clear_err = 1'b0;
        #2;
        chk_outs(tag, 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int c0;
        logic [3:0] eb;

        //       gray     clr  bin   v inc dec wrap err
        set_v(0,  4'b0110, 0, 4'd0, 0, 0, 0, 0, 0);
        set_v(1,  4'b0110, 0, 4'd0, 0, 0, 0, 0, 0);
        set_v(2,  4'b0110, 0, 4'd4, 1, 0, 0, 0, 0);
        set_v(3,  4'b0110, 0, 4'd4, 1, 0, 0, 0, 0);
        set_v(4,  4'b0010, 0, 4'd4, 1, 0, 0, 0, 0);
        set_v(5,  4'b0010, 0, 4'd4, 1, 0, 0, 0, 0);
        set_v(6,  4'b0011, 0, 4'd3, 1, 0, 1, 0, 0);
        set_v(7,  4'b0011, 0, 4'd3, 1, 0, 0, 0, 0);
        set_v(8,  4'b0001, 0, 4'd2, 1, 0, 1, 0, 0);
        set_v(9,  4'b0001, 0, 4'd2, 1, 0, 0, 0, 0);
        set_v(10, 4'b0000, 0, 4'd1, 1, 0, 1, 0, 0);
        set_v(11, 4'b0000, 0, 4'd1, 1, 0, 0, 0, 0);
        set_v(12, 4'b0101, 0, 4'd0, 1, 0, 1, 0, 0);
        set_v(13, 4'b0101, 0, 4'd0, 1, 0, 0, 0, 0);
        set_v(14, 4'b0101, 0, 4'd6, 1, 0, 0, 0, 1);
        set_v(15, 4'b0101, 0, 4'd6, 1, 0, 0, 0, 1);
        set_v(16, 4'b0101, 1, 4'd6, 1, 0, 0, 0, 0);
        set_v(17, 4'b0101, 0, 4'd6, 1, 0, 0, 0, 0);
        set_v(18, 4'b0000, 0, 4'd6, 1, 0, 0, 0, 0);
        set_v(19, 4'b0000, 0, 4'd6, 1, 0, 0, 0, 0);
        set_v(20, 4'b0000, 1, 4'd0, 1, 0, 0, 0, 1);
        set_v(21, 4'b0000, 0, 4'd0, 1, 0, 0, 0, 1);
        set_v(22, 4'b0000, 1, 4'd0, 1, 0, 0, 0, 0);
        set_v(23, 4'b0001, 0, 4'd0, 1, 0, 0, 0, 0);
        set_v(24, 4'b0001, 0, 4'd0, 1, 0, 0, 0, 0);
        set_v(25, 4'b0001, 0, 4'd1, 1, 1, 0, 0, 0);

        #50;
        chk_outs("reset_hold", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
        #3;

        do_reset("reset_tbl");
        for (int i = 0; i < 26; i++) begin
            i_gray = tbl[i].gray;
            i_clear_err = tbl[i].clr;
            tick();
            chk_outs("tbl", i, tbl[i].bin, tbl[i].v, tbl[i].inc, tbl[i].dec, tbl[i].wrap, tbl[i].err);
        end
        i_clear_err = 1'b0;

        // Free-running gray counter: decoded count trails by three edges.
        do_reset("reset_run");
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            i_gray = 4'(cnt) ^ (4'(cnt) >> 1);
            cnt = (cnt + 1) % 16;
            tick();
            eb = (k >= 2) ? 4'((k - 2) % 16) : 4'd0;
            chk_outs("run", k, eb, k >= 2, k >= 3, 1'b0, (k >= 3) && (eb == 4'd0), 1'b0);
        end

        // Asynchronous reset mid-count, then restart from the current count.
        #2;
        i_reset = 1'b1;
        #1;
        chk_outs("async_rst", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_outs("async_rst", 1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
        c0 = cnt;
        for (int k = 0; k < 6; k++) begin
            i_gray = 4'(cnt) ^ (4'(cnt) >> 1);
            cnt = (cnt + 1) % 16;
            tick();
            eb = (k >= 2) ? 4'((c0 + k - 2) % 16) : 4'd0;
            chk_outs("post_rst", k, eb, k >= 2, k >= 3, 1'b0, (k >= 3) && (eb == 4'd0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
